// File: rtl/receiver.sv
// receiver: UART receive stage, 16x oversampled, 8N1, ready/clear handshake
// clk       system clock, all logic on posedge
// rst       asynchronous active-high reset
// rx        serial line (asynchronous, idle high)
// clken     oversampling tick, OVERSAMPLE per bit period
// rdy_clr   host acknowledge, clears rdy and overrun
// dout      last correctly framed byte
// rdy       dout holds an unacknowledged byte
// frame_err last frame had a low stop bit
// overrun   a byte completed while rdy was still set
// rx_busy   a frame is in progress
`timescale 1ns/1ps
module receiver #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] dout,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [SW-1:0] sample, sample_n;
  logic [2:0] bitpos, bitpos_n;
  logic [7:0] scratch, scratch_n, dout_n;
  logic rdy_n, frame_err_n, overrun_n;
  logic [1:0] sync;
  logic rx_s;
  assign rx_s = sync[1];
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      state <= IDLE;
      sample <= '0;
      bitpos <= '0;
      scratch <= '0;
      dout <= '0;
      rdy <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      state <= state_n;
      sample <= sample_n;
      bitpos <= bitpos_n;
      scratch <= scratch_n;
      dout <= dout_n;
      rdy <= rdy_n;
      frame_err <= frame_err_n;
      overrun <= overrun_n;
    end
  // the acknowledge acts every clk; a byte completing on the same edge overrides it
  always_comb begin
    state_n = state;
    sample_n = sample;
    bitpos_n = bitpos;
    scratch_n = scratch;
    dout_n = dout;
    rdy_n = rdy & ~rdy_clr;
    frame_err_n = frame_err;
    overrun_n = overrun & ~rdy_clr;
    if (clken)
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          sample_n = SW'(1);
        end
        START: if (rx_s) state_n = IDLE;
          else if (sample == HALF) begin
            state_n = DATA;
            sample_n = '0;
            bitpos_n = '0;
          end else sample_n = sample + SW'(1);
        DATA: if (sample == LAST) begin
            scratch_n[bitpos] = rx_s;
            sample_n = '0;
            state_n = bitpos == 3'd7 ? STOP : DATA;
            bitpos_n = bitpos == 3'd7 ? bitpos : bitpos + 3'd1;
          end else sample_n = sample + SW'(1);
        STOP: if (sample == LAST) begin
            state_n = IDLE;
            sample_n = '0;
            if (rx_s) begin
              dout_n = scratch;
              rdy_n = 1'b1;
              frame_err_n = 1'b0;
              overrun_n = overrun_n | (rdy & ~rdy_clr);
            end else frame_err_n = 1'b1;
          end else sample_n = sample + SW'(1);
        default: state_n = IDLE;
      endcase
  end
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: scoreboard bench for the UART receiver
`timescale 1ns/1ps
module tb_receiver;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, clken = 1'b0, rdy_clr = 1'b0;
  logic [7:0] dout;
  logic rdy, frame_err, overrun, rx_busy;
  int div = 1;
  logic chk = 1'b0, pb = 1'b0;
  int checks = 0, passes = 0;
  typedef struct packed {logic [7:0] d; logic r; logic f; logic o;} exp_t;
  exp_t q[$];
  string nq[$];
  exp_t e;
  string n;

  receiver #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .rx(rx), .clken(clken), .rdy_clr(rdy_clr),
    .dout(dout), .rdy(rdy), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    clken = (div == 1) ? 1'b1 : ~clken;
  end

  // an output event is the end of a frame/glitch/reset (rx_busy falling) or an explicit probe
  always @(negedge clk) begin
    if ((pb && !rx_busy) || chk) begin
      checks++;
      if (q.size() == 0)
        $display("FAIL unexpected_event: got dout=%h rdy=%b ferr=%b ovr=%b, no event expected",
                 dout, rdy, frame_err, overrun);
      else begin
        e = q.pop_front();
        n = nq.pop_front();
        if ({dout, rdy, frame_err, overrun, rx_busy} === {e, 1'b0}) passes++;
        else
          $display("FAIL %s: got dout=%h rdy=%b ferr=%b ovr=%b busy=%b, expected dout=%h rdy=%b ferr=%b ovr=%b busy=0",
                   n, dout, rdy, frame_err, overrun, rx_busy, e.d, e.r, e.f, e.o);
      end
    end
    pb = rx_busy;
  end

  task automatic tick();
    @(posedge clk);
    while (!clken) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input string name, input logic [7:0] d, input logic r, input logic f, input logic o);
    q.push_back({d, r, f, o});
    nq.push_back(name);
  endtask

  task automatic probe(input string name, input logic [7:0] d, input logic r, input logic f, input logic o);
    expect_ev(name, d, r, f, o);
    chk = 1'b1;
    @(negedge clk);
    #1 chk = 1'b0;
  endtask

  task automatic idle(input int t);
    rx = 1'b1;
    repeat (t) tick();
  endtask

  task automatic clear(input string name, input logic [7:0] d, input logic f);
    rdy_clr = 1'b1;
    tick();
    rdy_clr = 1'b0;
    probe(name, d, 1'b0, f, 1'b0);
  endtask

  // 160 ticks per frame; the line returns high late in the stop bit so a low
  // stop bit cannot be mistaken for the next start bit
  task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int t = 0; t < 160; t++) begin
      if (t == rst_at) begin
        rst = 1'b1;
        rx = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      rx = (t >= 152) ? 1'b1 : bits[t / 16];
      rdy_clr = (t == clr_at);
      tick();
    end
    rdy_clr = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    probe("reset", 8'h00, 0, 0, 0);
    idle(20);
    expect_ev("mid_reset", 8'h00, 0, 0, 0);
    send_frame(8'h5A, 1, -1, 72);
    idle(32);
    expect_ev("rx_5a", 8'h5A, 1, 0, 0);
    send_frame(8'h5A, 1, -1, -1);
    clear("clr_5a", 8'h5A, 0);
    expect_ev("rx_a5", 8'hA5, 1, 0, 0);
    send_frame(8'hA5, 1, -1, -1);
    clear("clr_a5", 8'hA5, 0);
    expect_ev("glitch", 8'hA5, 0, 0, 0);
    rx = 1'b0;
    repeat (3) tick();
    idle(32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    probe("reset2", 8'h00, 0, 0, 0);
    idle(8);
    expect_ev("frame_err", 8'h00, 0, 1, 0);
    send_frame(8'h3C, 0, -1, -1);
    idle(32);
    div = 2;
    expect_ev("good_3c_slow", 8'h3C, 1, 0, 0);
    send_frame(8'h3C, 1, -1, -1);
    idle(8);
    div = 1;
    idle(4);
    clear("clr_3c", 8'h3C, 0);
    expect_ev("rx_11", 8'h11, 1, 0, 0);
    send_frame(8'h11, 1, -1, -1);
    expect_ev("overrun_22", 8'h22, 1, 0, 1);
    send_frame(8'h22, 1, -1, -1);
    clear("clr_overrun", 8'h22, 0);
    expect_ev("rx_66", 8'h66, 1, 0, 0);
    send_frame(8'h66, 1, -1, -1);
    expect_ev("coincident_77", 8'h77, 1, 0, 0);
    send_frame(8'h77, 1, 153, -1);
    idle(4);
    clear("clr_77", 8'h77, 0);
    idle(10);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL missing_events: got %0d pending, expected 0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule
